// File: rtl/sensor_cmd_pkg.sv
// sensor_cmd_pkg: command codes, status codes, FSM states and status-byte layout
package sensor_cmd_pkg;
  localparam logic [7:0] CMD_READ = 8'h01;
  localparam logic [7:0] CMD_CONT_START = 8'h03;
  localparam logic [7:0] CMD_CONT_STOP = 8'h04;
  typedef enum logic [3:0] {
    ST_OK = 4'd0,
    ST_BAD_CMD = 4'd1,
    ST_BAD_ADDR = 4'd2,
    ST_SENSOR_ERR = 4'd3,
    ST_TIMEOUT = 4'd4
  } status_e;
  typedef enum logic [2:0] {IDLE, GET_ADDR, REQUEST, WAIT_ACK, LOAD, SEND, WAIT_TX} state_e;
  localparam int STAT_OVR_BIT = 7;
  localparam int STAT_CODE_LSB = 0;
  localparam int STAT_CODE_W = 4;
  function automatic logic [7:0] status_byte(input logic ovr, input status_e code);
    logic [7:0] b;
    b = '0;
    b[STAT_OVR_BIT] = ovr;
    b[STAT_CODE_LSB +: STAT_CODE_W] = code;
    return b;
  endfunction
endpackage

// File: rtl/sensor_cmd_serializer.sv
// sensor_cmd_serializer: response shift register and tx_start/tx_done handshake
module sensor_cmd_serializer
  import sensor_cmd_pkg::*;
#(
  parameter int DATA_BYTES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    send,
  input  logic                    shift,
  input  logic [7:0]              status,
  input  logic [DATA_BYTES*8-1:0] data,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    last
);
  localparam int W = (DATA_BYTES + 1) * 8;
  logic [W-1:0] sr;
  logic [2:0] left;
  always_ff @(posedge clock)
    if (!reset) begin
      sr <= '0;
      left <= '0;
    end else if (load) begin
      sr <= {status, data};
      left <= 3'(DATA_BYTES);
    end else if (shift) begin
      sr <= sr << 8;
      left <= left - 3'd1;
    end
  assign tx_start = send && !tx_busy;
  assign tx_data = sr[W-1 -: 8];
  assign last = left == 3'd0;
endmodule

// File: rtl/sensor_command_unit.sv
// sensor_command_unit: UART command/response engine for sensor channels; SENSOR_CONTINUOUS_EN adds periodic re-reads
module sensor_command_unit
  import sensor_cmd_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_BYTES = 2,
  parameter int BYTE_TIMEOUT = 1_000_000,
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 rx_valid,
  input  logic [7:0]                           rx_data,
  output logic                                 tx_start,
  output logic [7:0]                           tx_data,
  input  logic                                 tx_busy,
  input  logic                                 tx_done,
  output logic [NUM_CHANNELS-1:0]              sensor_request,
  input  logic [NUM_CHANNELS-1:0]              sensor_ack,
  input  logic [NUM_CHANNELS-1:0]              sensor_error,
  input  logic [NUM_CHANNELS*DATA_BYTES*8-1:0] sensor_data,
  output logic [7:0]                           display_value,
  output logic                                 busy
);
`ifdef SENSOR_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  localparam int DW = DATA_BYTES * 8;
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int L0 = BYTE_TIMEOUT > ACK_TIMEOUT ? BYTE_TIMEOUT : ACK_TIMEOUT;
  localparam int LMAX = CONT && REPEAT_CYCLES > L0 ? REPEAT_CYCLES : L0;
  localparam int TW = $clog2(LMAX + 1);
  state_e state, state_nx;
  status_e code;
  logic [7:0] cmd;
  logic [CW-1:0] ch, rpt_ch;
  logic [DW-1:0] rdata, rd_slice;
  logic [TW-1:0] tmr;
  logic overrun, last, cmd_ok, addr_ok, ack, timeout, byte_to, repeat_due;
  assign rd_slice = sensor_data[ch*DW +: DW];
  assign ack = sensor_ack[ch];
  assign cmd_ok = cmd == CMD_READ || (CONT && (cmd == CMD_CONT_START || cmd == CMD_CONT_STOP));
  assign addr_ok = rx_data < 8'(NUM_CHANNELS);
  assign timeout = tmr == TW'(ACK_TIMEOUT - 1);
  assign byte_to = tmr == TW'(BYTE_TIMEOUT - 1);
  assign busy = state != IDLE;
`ifdef SENSOR_CONTINUOUS_EN
  logic cont;
  // The shared timer free-runs from IDLE entry and doubles as the repeat period.
  assign repeat_due = cont && tmr == TW'(REPEAT_CYCLES - 1);
  always_ff @(posedge clock)
    if (!reset) begin
      cont <= 1'b0;
      rpt_ch <= '0;
    end else if (state == GET_ADDR && rx_valid && addr_ok && cmd == CMD_CONT_START) begin
      cont <= 1'b1;
      rpt_ch <= rx_data[CW-1:0];
    end else if (state == GET_ADDR && rx_valid && addr_ok && cmd == CMD_CONT_STOP) begin
      cont <= 1'b0;
    end
`else
  assign repeat_due = 1'b0;
  assign rpt_ch = '0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = rx_valid ? GET_ADDR : repeat_due ? REQUEST : IDLE;
      GET_ADDR: state_nx = rx_valid ? (cmd_ok && addr_ok && cmd != CMD_CONT_STOP ? REQUEST : LOAD)
                                    : byte_to ? IDLE : GET_ADDR;
      REQUEST:  state_nx = WAIT_ACK;
      WAIT_ACK: state_nx = ack || timeout ? LOAD : WAIT_ACK;
      LOAD:     state_nx = SEND;
      SEND:     state_nx = tx_start ? WAIT_TX : SEND;
      WAIT_TX:  state_nx = tx_done ? (last ? IDLE : SEND) : WAIT_TX;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      tmr <= '0;
      cmd <= '0;
      ch <= '0;
      code <= ST_OK;
      rdata <= '0;
      overrun <= 1'b0;
      display_value <= '0;
      sensor_request <= '0;
    end else begin
      state <= state_nx;
      tmr <= state_nx != state ? '0 : tmr + 1'b1;
      sensor_request <= state_nx == WAIT_ACK ? NUM_CHANNELS'(1) << ch : '0;
      overrun <= (overrun && state != LOAD) || (rx_valid && state != IDLE && state != GET_ADDR);
      if (state == IDLE && rx_valid) cmd <= rx_data;
      if (state == IDLE && !rx_valid && repeat_due) ch <= rpt_ch;
      if (state == GET_ADDR && rx_valid) begin
        ch <= rx_data[CW-1:0];
        rdata <= '0;
        code <= !cmd_ok ? ST_BAD_CMD : !addr_ok ? ST_BAD_ADDR : ST_OK;
      end
      if (state == WAIT_ACK && (ack || timeout)) begin
        rdata <= ack && !sensor_error[ch] ? rd_slice : '0;
        code <= !ack ? ST_TIMEOUT : sensor_error[ch] ? ST_SENSOR_ERR : ST_OK;
        if (ack && !sensor_error[ch]) display_value <= rd_slice[7:0];
      end
    end
  sensor_cmd_serializer #(.DATA_BYTES(DATA_BYTES)) u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (state == LOAD),
    .send     (state == SEND),
    .shift    (state == WAIT_TX && tx_done),
    .status   (status_byte(overrun, code)),
    .data     (rdata),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .last     (last)
  );
endmodule

// File: doc/sensor_command_unit.md
# sensor_command_unit

Parametrised command/response engine between the UART byte receiver and transmitter in the digital-sensor design. Accepts two-byte host commands (command, channel address), runs a request/acknowledge transaction with one of NUM_CHANNELS sensor channels, and returns a fixed-length response. The response is a status byte followed by DATA_BYTES data bytes. It replaces the direct RX-to-TX echo path and drives the seven-segment decoders with the last valid reading.

## Interface
- NUM_CHANNELS, 8: number of sensor channels; legal 1..32.
- DATA_BYTES, 2: bytes per reading; legal 1..4.
- BYTE_TIMEOUT, 1_000_000: max cycles between command byte and address byte.
- ACK_TIMEOUT, 2_000_000: max cycles waiting for sensor_ack.
- REPEAT_CYCLES, 5_000_000: continuous-mode read period; used only with SENSOR_CONTINUOUS_EN.

- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the clock edge.
- rx_valid  in  1  one-cycle pulse; rx_data is valid.
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle pulse; transmitter loads tx_data.
- tx_data  out  8  byte to send; stable from tx_start until tx_done.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  one-cycle pulse at end of stop bit.
- sensor_request  out  NUM_CHANNELS  one-hot request level.
- sensor_ack  in  NUM_CHANNELS  per-channel completion pulse.
- sensor_error  in  NUM_CHANNELS  per-channel error; qualified by sensor_ack.
- sensor_data  in  NUM_CHANNELS*DATA_BYTES*8  channel c occupies bits [c*DATA_BYTES*8 +: DATA_BYTES*8].
- display_value  out  8  low byte of the last successful reading.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Commands:
  - 0x01 READ.
  - 0x03 CONT_START and 0x04 CONT_STOP exist only with the macro.
  - Any other command byte is BAD_CMD.
- Status byte = {overrun, 3'b000, code[3:0]}. Codes:
  - 0 OK
  - 1 BAD_CMD
  - 2 BAD_ADDR (address >= NUM_CHANNELS)
  - 3 SENSOR_ERR
  - 4 TIMEOUT
- Response is always 1+DATA_BYTES bytes. Data bytes go out MSB first; they are all 0x00 unless code is 0.
- FSM states: IDLE, GET_ADDR, REQUEST, WAIT_ACK, LOAD, SEND, WAIT_TX.
  - IDLE --rx_valid--> GET_ADDR; command byte is latched.
  - GET_ADDR --rx_valid--> REQUEST if command and address are valid; otherwise LOAD with the error code.
  - GET_ADDR --BYTE_TIMEOUT cycles with no byte--> IDLE. The partial command is discarded and no response is sent.
  - REQUEST: assert sensor_request[addr], go to WAIT_ACK.
  - WAIT_ACK --sensor_ack[addr]--> LOAD. Data is latched on the same edge; code is 3 if sensor_error[addr], else 0. Acks on other channels are ignored.
  - WAIT_ACK --ACK_TIMEOUT cycles--> LOAD with code 4.
  - LOAD: the response shift register is loaded. SEND issues tx_start when tx_busy is low. WAIT_TX waits for tx_done, then sends the next byte or goes to IDLE after the last byte.
- An rx_valid in any state other than IDLE or GET_ADDR discards the byte and sets a sticky overrun flag. The flag goes out in the next status byte and clears on LOAD.
- display_value updates only on code 0.

## Timing
- Reset values:
  - tx_start, sensor_request, busy: 0.
  - tx_data, display_value: 0x00.
  - overrun: 0.
  - State: IDLE. Continuous flag: clear.
- Reset mid-transaction aborts immediately. sensor_request drops on the reset edge, and any byte in flight in the transmitter is not re-issued.
- sensor_request rises 2 cycles after the address rx_valid edge. It falls the cycle after the ack edge or the timeout edge.
- First tx_start comes 2 cycles after the ack edge if tx_busy is low; otherwise it comes in the first cycle with tx_busy low.
- Error paths (BAD_CMD, BAD_ADDR) skip REQUEST entirely. First tx_start comes 2 cycles after the address byte.
- Ack arriving in the same cycle as timeout expiry: the ack wins.
- Timeout counters clear on state entry. Expiry happens at count == limit-1.

## Configuration
- SENSOR_CONTINUOUS_EN defined:
  - CONT_START behaves as READ, then sets the continuous flag for that address.
  - While the flag is set, in IDLE a REPEAT_CYCLES counter reissues READ on that address.
  - CONT_STOP clears the flag and responds code 0 with zero data.
  - Any received command byte pre-empts the pending repeat.
- SENSOR_CONTINUOUS_EN undefined: 0x03 and 0x04 respond BAD_CMD; no repeat counter is synthesised.

## Structure
- Package sensor_cmd_pkg holds:
  - command codes;
  - status codes;
  - the FSM state enum;
  - the status-byte field positions.
- Sub-module sensor_cmd_serializer holds the response shift register and the tx_start/tx_done handshake (LOAD/SEND/WAIT_TX).

## Test plan
- NUM_CHANNELS=8, DATA_BYTES=2:
  - Send 0x01,0x05; channel 5 acks with data 0x1234 and no error. Require sensor_request=8'b0010_0000 and bytes 0x00,0x12,0x34; display_value=0x34.
  - Send 0x07,0x00. Require no sensor_request and bytes 0x01,0x00,0x00. Send 0x01,0x09. Require 0x02,0x00,0x00.
  - Send 0x01,0x02 with no ack. Require sensor_request to drop after ACK_TIMEOUT, then 0x04,0x00,0x00. Repeat with ack plus sensor_error: require 0x03,0x00,0x00.
  - Send 0x01 only, wait BYTE_TIMEOUT+10. Require no tx_start and busy=0. Then send 0x01,0x03: normal response.
  - Inject an rx byte during WAIT_TX. Require the current response unchanged and the next status byte 0x80.
  - With the macro: send 0x03,0x01. Require a response every REPEAT_CYCLES until 0x04,0x01 returns 0x00,0x00,0x00 and repeats stop. Assert reset mid-SEND: all outputs return to reset values next cycle.
